// File: rtl/fpu_comp_arbiter.sv
// ---------------------------------------------------------------------------
// fpu_comp_arbiter
//   Round-robin arbiter sharing one registered fp16 compare unit among
//   NUM_REQ requesters. Each requester may have one op in flight. A {valid,tag}
//   pipeline runs alongside the comparator, and when a result comes out it is
//   written to that requester's response slot. The slot holds the A>=B bit
//   until the requester consumes it.
//
// Ports
//   aclk, areset        clock, synchronous active-high reset
//   req_valid/ready     per-requester handshake (req_ready is a one-hot grant)
//   req_a/b_tdata       packed fp16 operands, slice [16i+15:16i]
//   cmp_a/b_tdata       registered operands to the comparator
//   cmp_a/b_tvalid      registered issue strobe (both carry the same value)
//   cmp_result_tdata    comparator result, bit0 = A>=B
//   cmp_result_tvalid   comparator valid, used only by the consistency check
//   rsp_valid/ge/ready  per-requester response slot
//   err                 sticky tag/valid mismatch flag
//
// Configuration macro
//   FPU_ARB_CHECK_EN    when defined, cmp_result_tvalid is compared with the
//                       tag pipeline output valid on every cycle. A mismatch
//                       sets err. When undefined, err is tied to 0.
// ---------------------------------------------------------------------------
module fpu_comp_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int CMP_LAT = 1,
    parameter int TAG_W   = 2
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [16*NUM_REQ-1:0]  req_a_tdata,
    input  logic [16*NUM_REQ-1:0]  req_b_tdata,
    output logic [15:0]            cmp_a_tdata,
    output logic [15:0]            cmp_b_tdata,
    output logic                   cmp_a_tvalid,
    output logic                   cmp_b_tvalid,
    input  logic [7:0]             cmp_result_tdata,
    input  logic                   cmp_result_tvalid,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [NUM_REQ-1:0]     rsp_ge,
    input  logic [NUM_REQ-1:0]     rsp_ready,
    output logic                   err
);

    logic [TAG_W-1:0]   ptr_q, ptr_d;
    logic [NUM_REQ-1:0] busy_q, busy_d;
    logic [15:0]        cmp_a_q, cmp_a_d;
    logic [15:0]        cmp_b_q, cmp_b_d;
    logic               iss_vld_q, iss_vld_d;
    logic [TAG_W-1:0]   iss_tag_q, iss_tag_d;
    logic [CMP_LAT-1:0] pipe_vld_q, pipe_vld_d;
    logic [TAG_W-1:0]   pipe_tag_q [CMP_LAT];
    logic [TAG_W-1:0]   pipe_tag_d [CMP_LAT];
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [NUM_REQ-1:0] rsp_ge_q, rsp_ge_d;

    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] gnt_oh;
    logic               gnt_any;
    int                 gnt_int;
    int                 idx;
    logic [NUM_REQ-1:0] consume;
    logic               out_vld;
    logic [TAG_W-1:0]   out_tag;

    assign out_vld = pipe_vld_q[CMP_LAT-1];
    assign out_tag = pipe_tag_q[CMP_LAT-1];

    // Gating with areset keeps req_ready low while reset is asserted.
    assign elig    = req_valid & ~busy_q & {NUM_REQ{~areset}};
    assign consume = rsp_valid_q & rsp_ready;

    // Pick the first eligible requester at or after ptr, wrapping around.
    always_comb begin
        gnt_oh  = '0;
        gnt_any = 1'b0;
        gnt_int = 0;
        idx     = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = (int'(ptr_q) + off) % NUM_REQ;
            if (!gnt_any && elig[idx]) begin
                gnt_oh[idx] = 1'b1;
                gnt_any     = 1'b1;
                gnt_int     = idx;
            end
        end
    end

    always_comb begin
        ptr_d     = ptr_q;
        cmp_a_d   = cmp_a_q;
        cmp_b_d   = cmp_b_q;
        iss_vld_d = gnt_any;
        iss_tag_d = iss_tag_q;
        if (gnt_any) begin
            ptr_d     = TAG_W'((gnt_int + 1) % NUM_REQ);
            cmp_a_d   = req_a_tdata[16*gnt_int +: 16];
            cmp_b_d   = req_b_tdata[16*gnt_int +: 16];
            iss_tag_d = TAG_W'(gnt_int);
        end

        // The tag pipeline advances in step with the comparator's input register.
        pipe_vld_d    = '0;
        pipe_vld_d[0] = iss_vld_q;
        for (int s = 0; s < CMP_LAT; s++) begin
            pipe_tag_d[s] = '0;
        end
        pipe_tag_d[0] = iss_tag_q;
        for (int s = 1; s < CMP_LAT; s++) begin
            pipe_vld_d[s] = pipe_vld_q[s-1];
            pipe_tag_d[s] = pipe_tag_q[s-1];
        end

        busy_d      = (busy_q & ~consume) | gnt_oh;
        rsp_valid_d = rsp_valid_q & ~consume;
        rsp_ge_d    = rsp_ge_q;
        // busy keeps a retire from ever landing on an occupied slot.
        if (out_vld) begin
            rsp_valid_d[out_tag] = 1'b1;
            rsp_ge_d[out_tag]    = cmp_result_tdata[0];
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            ptr_q       <= '0;
            busy_q      <= '0;
            cmp_a_q     <= '0;
            cmp_b_q     <= '0;
            iss_vld_q   <= 1'b0;
            iss_tag_q   <= '0;
            pipe_vld_q  <= '0;
            for (int s = 0; s < CMP_LAT; s++) begin
                pipe_tag_q[s] <= '0;
            end
            rsp_valid_q <= '0;
            rsp_ge_q    <= '0;
        end else begin
            ptr_q       <= ptr_d;
            busy_q      <= busy_d;
            cmp_a_q     <= cmp_a_d;
            cmp_b_q     <= cmp_b_d;
            iss_vld_q   <= iss_vld_d;
            iss_tag_q   <= iss_tag_d;
            pipe_vld_q  <= pipe_vld_d;
            for (int s = 0; s < CMP_LAT; s++) begin
                pipe_tag_q[s] <= pipe_tag_d[s];
            end
            rsp_valid_q <= rsp_valid_d;
            rsp_ge_q    <= rsp_ge_d;
        end
    end

`ifdef FPU_ARB_CHECK_EN
    logic err_q, err_d;

    assign err_d = err_q | (cmp_result_tvalid != out_vld);

    always_ff @(posedge aclk) begin
        if (areset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;

    logic unused_ok;
    assign unused_ok = &{1'b0, cmp_result_tdata[7:1]};
`else
    assign err = 1'b0;

    logic unused_ok;
    assign unused_ok = &{1'b0, cmp_result_tvalid, cmp_result_tdata[7:1]};
`endif

    assign req_ready    = gnt_oh;
    assign cmp_a_tdata  = cmp_a_q;
    assign cmp_b_tdata  = cmp_b_q;
    assign cmp_a_tvalid = iss_vld_q;
    assign cmp_b_tvalid = iss_vld_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_ge       = rsp_ge_q;

endmodule

// File: tb/tb_fpu_comp_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fpu_comp_arbiter
//   Directed bench for fpu_comp_arbiter. A behavioural 1-cycle registered fp16
//   comparator stands in for fpu_comp_large. Its upper result bits are set to
//   junk. When FPU_ARB_CHECK_EN is defined, the err path is also exercised.
// ---------------------------------------------------------------------------
module tb_fpu_comp_arbiter;

    localparam int NUM_REQ = 4;

    logic                  aclk = 1'b0;
    logic                  areset = 1'b1;
    logic [NUM_REQ-1:0]    req_valid = '0;
    logic [NUM_REQ-1:0]    req_ready;
    logic [16*NUM_REQ-1:0] req_a_tdata = '0;
    logic [16*NUM_REQ-1:0] req_b_tdata = '0;
    logic [15:0]           cmp_a_tdata, cmp_b_tdata;
    logic                  cmp_a_tvalid, cmp_b_tvalid;
    logic [7:0]            cmp_result_tdata = '0;
    logic                  cmp_result_tvalid;
    logic [NUM_REQ-1:0]    rsp_valid, rsp_ge;
    logic [NUM_REQ-1:0]    rsp_ready = '0;
    logic                  err;

    logic res_vld_raw = 1'b0;
    logic force_low   = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;

    fpu_comp_arbiter #(.NUM_REQ(NUM_REQ), .CMP_LAT(1), .TAG_W(2)) dut (
        .aclk              (aclk),
        .areset            (areset),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_a_tdata       (req_a_tdata),
        .req_b_tdata       (req_b_tdata),
        .cmp_a_tdata       (cmp_a_tdata),
        .cmp_b_tdata       (cmp_b_tdata),
        .cmp_a_tvalid      (cmp_a_tvalid),
        .cmp_b_tvalid      (cmp_b_tvalid),
        .cmp_result_tdata  (cmp_result_tdata),
        .cmp_result_tvalid (cmp_result_tvalid),
        .rsp_valid         (rsp_valid),
        .rsp_ge            (rsp_ge),
        .rsp_ready         (rsp_ready),
        .err               (err)
    );

    always #5 aclk = ~aclk;

    // Signed-magnitude fp16 >= (the values used here contain no NaNs).
    function automatic logic fp16_ge(input logic [15:0] a, input logic [15:0] b);
        if (a[14:0] == 15'd0 && b[14:0] == 15'd0) return 1'b1;
        if (a[15] != b[15]) return b[15];
        if (!a[15]) return a[14:0] >= b[14:0];
        return a[14:0] <= b[14:0];
    endfunction

    always @(posedge aclk) begin
        res_vld_raw      <= cmp_a_tvalid;
        cmp_result_tdata <= {7'h55, fp16_ge(cmp_a_tdata, cmp_b_tdata)};
    end
    assign cmp_result_tvalid = res_vld_raw & ~force_low;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        tick();
        tick();
        areset = 1'b0;
    endtask

    task automatic set_ops(input int i, input logic [15:0] a, input logic [15:0] b);
        req_a_tdata[16*i +: 16] = a;
        req_b_tdata[16*i +: 16] = b;
    endtask

    // A single op on requester 0: accept, response two edges later, then consume.
    task automatic single0(input logic [15:0] a, input logic [15:0] b, input logic exp_ge);
        set_ops(0, a, b);
        req_valid = 4'b0001;
        #1;
        chk("t2_ready", req_ready, 4'b0001);
        tick();
        req_valid = 4'b0000;
        chk("t2_issue_vld", {cmp_a_tvalid, cmp_b_tvalid}, 2'b11);
        chk("t2_issue_a", cmp_a_tdata, a);
        chk("t2_issue_b", cmp_b_tdata, b);
        chk("t2_rsp_early0", rsp_valid, 4'b0000);
        tick();
        chk("t2_rsp_early1", rsp_valid, 4'b0000);
        tick();
        chk("t2_rsp_vld", rsp_valid, 4'b0001);
        chk("t2_rsp_ge", rsp_ge[0], exp_ge);
        tick();
        chk("t2_rsp_clr", rsp_valid, 4'b0000);
    endtask

    initial begin
        int c0;
        int c2;
        logic [3:0] ge_exp;
        logic [3:0] exp_rdy;

        // 1: reset with every requester asking
        req_valid = 4'hF;
        tick();
        tick();
        #1;
        chk("t1_ready", req_ready, 4'b0000);
        chk("t1_rsp", rsp_valid, 4'b0000);
        chk("t1_tvalid", cmp_a_tvalid, 1'b0);
        chk("t1_err", err, 1'b0);
        req_valid = 4'h0;
        areset = 1'b0;
        tick();

        // 2: single-requester compares
        rsp_ready = 4'b0001;
        single0(16'h4000, 16'h3C00, 1'b1);
        single0(16'h3C00, 16'h4000, 1'b0);
        single0(16'hC500, 16'hC500, 1'b1);
        single0(16'hC000, 16'h3C00, 1'b0);

        // 3: all four at once from ptr=0
        do_reset();
        set_ops(0, 16'h4000, 16'h3C00);
        set_ops(1, 16'h3C00, 16'h4000);
        set_ops(2, 16'hC500, 16'hC500);
        set_ops(3, 16'hC000, 16'hBC00);
        ge_exp    = 4'b0101;
        rsp_ready = 4'hF;
        req_valid = 4'hF;
        for (int s = 0; s < 8; s++) begin
            if (s == 4) req_valid = 4'h0;
            #1;
            chk("t3_ready", req_ready, (s < 4) ? (32'd1 << s) : 32'd0);
            if (s >= 3 && s <= 6) begin
                chk("t3_rsp_vld", rsp_valid, 32'd1 << (s - 3));
                chk("t3_rsp_ge", rsp_ge[s-3], ge_exp[s-3]);
            end else begin
                chk("t3_rsp_none", rsp_valid, 4'b0000);
            end
            tick();
        end

        // 4: requesters 0 and 2 both held valid; each is busy for 3 edges per op
        req_valid = 4'b0101;
        c0 = 0;
        c2 = 0;
        for (int s = 0; s < 12; s++) begin
            #1;
            exp_rdy = (s % 4 == 0) ? 4'b0001 : ((s % 4 == 1) ? 4'b0100 : 4'b0000);
            chk("t4_ready", req_ready, exp_rdy);
            if (req_ready[0]) c0++;
            if (req_ready[2]) c2++;
            tick();
        end
        chk("t4_cnt0", c0, 3);
        chk("t4_cnt2", c2, 3);
        req_valid = 4'h0;
        repeat (4) tick();

        // 5: requester 1 keeps its response unconsumed
        rsp_ready = 4'b1101;
        set_ops(1, 16'h3C00, 16'h3C00);
        req_valid = 4'b0010;
        #1;
        chk("t5_first", req_ready, 4'b0010);
        tick();
        req_valid = 4'b0000;
        tick();
        tick();
        chk("t5_rsp1", rsp_valid[1], 1'b1);
        chk("t5_ge1", rsp_ge[1], 1'b1);
        req_valid = 4'b1011;
        #1;
        chk("t5_a_ready", req_ready, 4'b1000);
        tick();
        chk("t5_b_ready", req_ready, 4'b0001);
        chk("t5_b_hold", rsp_valid[1], 1'b1);
        tick();
        req_valid = 4'b0010;
        rsp_ready = 4'hF;
        #1;
        chk("t5_c_ready", req_ready, 4'b0000);
        chk("t5_c_hold", rsp_valid[1], 1'b1);
        tick();
        chk("t5_d_clr", rsp_valid[1], 1'b0);
        chk("t5_d_ready", req_ready, 4'b0010);
        tick();
        req_valid = 4'b0000;
        repeat (5) tick();

        // 6: reset one cycle after requester 3 is accepted
        req_valid = 4'b1000;
        #1;
        chk("t6_ready3", req_ready, 4'b1000);
        tick();
        req_valid = 4'b0000;
        areset = 1'b1;
        tick();
        areset = 1'b0;
        chk("t6_rsp0", rsp_valid, 4'b0000);
        tick();
        chk("t6_rsp1", rsp_valid, 4'b0000);
        tick();
        chk("t6_rsp2", rsp_valid, 4'b0000);
        req_valid = 4'hF;
        #1;
        chk("t6_ptr0", req_ready, 4'b0001);
        req_valid = 4'h0;
`ifndef FPU_ARB_CHECK_EN
        chk("t6_err_tied", err, 1'b0);
`else
        rsp_ready = 4'h0;
        do_reset();
        chk("t6_err_clr", err, 1'b0);
        force_low = 1'b1;
        set_ops(0, 16'h4000, 16'h3C00);
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b0000;
        repeat (3) tick();
        chk("t6_err_set", err, 1'b1);
        chk("t6_err_retire", rsp_valid, 4'b0001);
        force_low = 1'b0;
        repeat (3) tick();
        chk("t6_err_held", err, 1'b1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
